// File: rtl/wr_data_ctrl_if.sv
// Bus bundle between the acquisition/DDR side and wr_data_ctrl.
// The slave modport is the sequencer. The master modport is whoever drives the
// beats and the finish strobes.
interface wr_data_ctrl_if;
  logic        in_valid;
  logic        pl_ddr_wr_finish;
  logic        pl_ddr_rd_finish;
  logic        pl_ddr_wr_start;
  logic [31:0] pl_ddr_wr_length;
  logic [31:0] pl_ddr_wr_addr;
  logic [12:0] ring_level;
  logic        busy;
  logic        overrun;
  logic        wr_timeout;

  modport master (
    output in_valid, pl_ddr_wr_finish, pl_ddr_rd_finish,
    input  pl_ddr_wr_start, pl_ddr_wr_length, pl_ddr_wr_addr, ring_level, busy, overrun,
           wr_timeout
  );

  modport slave (
    input  in_valid, pl_ddr_wr_finish, pl_ddr_rd_finish,
    output pl_ddr_wr_start, pl_ddr_wr_length, pl_ddr_wr_addr, ring_level, busy, overrun,
           wr_timeout
  );
endinterface

// File: rtl/wr_data_ctrl.sv
// Write-side sequencer for the PL DDR ring buffer.
// It counts beats in the upstream FIFO and launches one burst per full block.
// It also tracks ring occupancy, so unread blocks are never overwritten.
// Optional WAIT_FIN watchdog: define WR_CTRL_TIMEOUT_EN.
module wr_data_ctrl #(
  parameter int unsigned BLOCK_LEN   = 32000,
  parameter int unsigned BEAT_BYTES  = 4,
  parameter int unsigned RING_SIZE   = 192_000_000,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FIFO_BEATS  = 16384
`ifdef WR_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
`endif
) (
  input logic           pl_clk,
  input logic           rst_n,
  wr_data_ctrl_if.slave bus
);

  localparam logic [14:0] BlockBeats = 15'(BLOCK_LEN / BEAT_BYTES);
  localparam logic [14:0] FifoBeats  = 15'(FIFO_BEATS);
  localparam logic [12:0] RingBlocks = 13'(RING_SIZE / BLOCK_LEN);
  localparam logic [31:0] BaseAddr   = 32'(BASE_ADDR);
  localparam logic [31:0] LastAddr   = 32'(BASE_ADDR + RING_SIZE - BLOCK_LEN);
  localparam logic [31:0] BlockLen   = 32'(BLOCK_LEN);

  typedef enum logic [1:0] {StIdle, StStart, StWaitFin} state_e;

  state_e      state;
  logic        wr_finish_d, rd_finish_d;
  logic        wr_fin_re, rd_fin_re;
  logic        launch, wr_done;
  logic [14:0] avail;
  logic [12:0] ring_level;
  logic [31:0] wr_addr, wr_length;
  logic        wr_start, overrun, wr_timeout;

  assign wr_fin_re = bus.pl_ddr_wr_finish & ~wr_finish_d;
  assign rd_fin_re = bus.pl_ddr_rd_finish & ~rd_finish_d;
  // Launch decision made in IDLE; the same term drives the beat consumption.
  assign launch    = (state == StIdle) && (avail >= BlockBeats) && (ring_level < RingBlocks);
  assign wr_done   = (state == StWaitFin) && wr_fin_re;

  // Finish strobes may be levels; keep one stage for rising-edge detection.
  always_ff @(posedge pl_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_finish_d <= 1'b0;
      rd_finish_d <= 1'b0;
    end else begin
      wr_finish_d <= bus.pl_ddr_wr_finish;
      rd_finish_d <= bus.pl_ddr_rd_finish;
    end
  end

  // FIFO beat occupancy; saturates at FIFO depth and flags overrun (sticky).
  always_ff @(posedge pl_clk or negedge rst_n) begin
    if (!rst_n) begin
      avail   <= '0;
      overrun <= 1'b0;
    end else if (launch) begin
      avail <= avail + {14'd0, bus.in_valid} - BlockBeats;
    end else if (bus.in_valid) begin
      if (avail == FifoBeats) begin
        overrun <= 1'b1;
      end else begin
        avail <= avail + 15'd1;
      end
    end
  end

  // Ring occupancy: completed writes in, read completions out, floor at zero.
  always_ff @(posedge pl_clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_level <= '0;
    end else if (wr_done && !rd_fin_re) begin
      ring_level <= ring_level + 13'd1;
    end else if (!wr_done && rd_fin_re && (ring_level != '0)) begin
      ring_level <= ring_level - 13'd1;
    end
  end

`ifdef WR_CTRL_TIMEOUT_EN
  localparam logic [19:0] TmoLast = 20'(TIMEOUT_CYC - 1);
  logic [19:0] tmo_cnt;
`endif

  // Burst FSM with registered launch pulse, length and address.
  always_ff @(posedge pl_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      wr_start   <= 1'b0;
      wr_length  <= '0;
      wr_addr    <= BaseAddr;
`ifdef WR_CTRL_TIMEOUT_EN
      tmo_cnt    <= '0;
      wr_timeout <= 1'b0;
`endif
    end else begin
      wr_length <= BlockLen;
      wr_start  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (launch) begin
            state    <= StStart;
            wr_start <= 1'b1;
          end
        end
        StStart: begin
          state <= StWaitFin;
`ifdef WR_CTRL_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        StWaitFin: begin
          // A finish edge on the limit cycle still counts as success.
          if (wr_fin_re) begin
            wr_addr <= (wr_addr == LastAddr) ? BaseAddr : wr_addr + BlockLen;
            state   <= StIdle;
`ifdef WR_CTRL_TIMEOUT_EN
          end else if (tmo_cnt == TmoLast) begin
            // Address is kept, so the same block is relaunched.
            wr_timeout <= 1'b1;
            state      <= StIdle;
          end else begin
            tmo_cnt <= tmo_cnt + 20'd1;
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifndef WR_CTRL_TIMEOUT_EN
  assign wr_timeout = 1'b0;
`endif

  assign bus.pl_ddr_wr_start  = wr_start;
  assign bus.pl_ddr_wr_length = wr_length;
  assign bus.pl_ddr_wr_addr   = wr_addr;
  assign bus.ring_level       = ring_level;
  assign bus.busy             = (state != StIdle);
  assign bus.overrun          = overrun;
  assign bus.wr_timeout       = wr_timeout;

endmodule

// File: tb/tb_wr_data_ctrl.sv
// Bench for wr_data_ctrl with a scaled-down ring: 8 beats per block, 6 blocks,
// a 20-beat FIFO and a 100-cycle watchdog.
// Expected addresses and levels come from a block-count model. The address is
// taken modulo the ring and the level is writes minus reads, floored at 0.
`timescale 1ns/1ps
module tb_wr_data_ctrl;
  localparam int unsigned BLOCK_LEN   = 32;
  localparam int unsigned BEAT_BYTES  = 4;
  localparam int unsigned RING_SIZE   = 192;
  localparam int unsigned BASE_ADDR   = 0;
  localparam int unsigned FIFO_BEATS  = 20;
  localparam int unsigned TIMEOUT_CYC = 100;
  localparam int unsigned BLOCK_BEATS = BLOCK_LEN / BEAT_BYTES;
  localparam int unsigned RING_BLOCKS = RING_SIZE / BLOCK_LEN;

  logic pl_clk = 1'b0;
  logic rst_n  = 1'b0;
  wr_data_ctrl_if bus();

  wr_data_ctrl #(
    .BLOCK_LEN  (BLOCK_LEN),
    .BEAT_BYTES (BEAT_BYTES),
    .RING_SIZE  (RING_SIZE),
    .BASE_ADDR  (BASE_ADDR),
    .FIFO_BEATS (FIFO_BEATS)
`ifdef WR_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
  ) dut (
    .pl_clk(pl_clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 pl_clk = ~pl_clk;

  int checks = 0;
  int errors = 0;
  int starts_seen = 0;
  int wr_done = 0;  // blocks completed since reset
  int lvl_m = 0;    // model ring occupancy

  always @(posedge pl_clk) if (bus.pl_ddr_wr_start === 1'b1) starts_seen++;

  function automatic logic [31:0] exp_addr();
    return 32'(BASE_ADDR + (wr_done % RING_BLOCKS) * BLOCK_LEN);
  endfunction

  task automatic tick();
    @(posedge pl_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_beats(input int n);
    int sent = 0;
    while (sent < n) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      tick();
      if (bus.in_valid) sent++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int i = 0;
    while (bus.pl_ddr_wr_start !== 1'b1 && i < 200) begin
      tick();
      i++;
    end
    chk("start_seen", 32'(bus.pl_ddr_wr_start), 32'd1);
  endtask

  task automatic launch_and_check(input string tag);
    wait_start();
    chk({tag, "_addr"}, bus.pl_ddr_wr_addr, exp_addr());
    chk({tag, "_len"}, bus.pl_ddr_wr_length, 32'(BLOCK_LEN));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    tick();
    chk({tag, "_pulse1"}, 32'(bus.pl_ddr_wr_start), 32'd0);
  endtask

  // One clean rising edge on the chosen strobes, then a quiet cycle.
  task automatic finish(input logic w, input logic r);
    bus.pl_ddr_wr_finish = w;
    bus.pl_ddr_rd_finish = r;
    tick();
    bus.pl_ddr_wr_finish = 1'b0;
    bus.pl_ddr_rd_finish = 1'b0;
    tick();
  endtask

  task automatic do_block(input string tag);
    send_beats(BLOCK_BEATS);
    launch_and_check(tag);
    finish(1'b1, 1'b0);
    wr_done++;
    lvl_m++;
    chk({tag, "_lvl"}, 32'(bus.ring_level), 32'(lvl_m));
    chk({tag, "_next"}, bus.pl_ddr_wr_addr, exp_addr());
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start"}, 32'(bus.pl_ddr_wr_start), 32'd0);
    chk({tag, "_len"}, bus.pl_ddr_wr_length, 32'd0);
    chk({tag, "_addr"}, bus.pl_ddr_wr_addr, 32'(BASE_ADDR));
    chk({tag, "_lvl"}, 32'(bus.ring_level), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_ovr"}, 32'(bus.overrun), 32'd0);
    chk({tag, "_tmo"}, 32'(bus.wr_timeout), 32'd0);
  endtask

  initial begin
    int s0;
    int n;
    bus.in_valid = 1'b0;
    bus.pl_ddr_wr_finish = 1'b0;
    bus.pl_ddr_rd_finish = 1'b0;

    // Reset state, then length valid from the first clock after release
    repeat (3) tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    chk("len_after_rst", bus.pl_ddr_wr_length, 32'(BLOCK_LEN));

    // Fill the whole ring with no reads; the final address wraps to base
    for (int b = 0; b < int'(RING_BLOCKS); b++) do_block("blk");
    chk("full_lvl", 32'(bus.ring_level), 32'(RING_BLOCKS));
    chk("wrap_addr", bus.pl_ddr_wr_addr, 32'(BASE_ADDR));

    // Ring full: data waiting but no launch until one block is read
    s0 = starts_seen;
    send_beats(BLOCK_BEATS);
    repeat (20) tick();
    chk("full_no_start", 32'(starts_seen - s0), 32'd0);
    chk("full_idle", 32'(bus.busy), 32'd0);
    finish(1'b0, 1'b1);
    lvl_m--;
    chk("rd_free_lvl", 32'(bus.ring_level), 32'(lvl_m));
    launch_and_check("after_rd");

    // Write and read completions on the same edge cancel out
    finish(1'b1, 1'b1);
    wr_done++;
    chk("both_lvl", 32'(bus.ring_level), 32'(lvl_m));
    chk("both_addr", bus.pl_ddr_wr_addr, exp_addr());

    // Write finish while idle is ignored
    finish(1'b1, 1'b0);
    chk("idle_fin_lvl", 32'(bus.ring_level), 32'(lvl_m));
    chk("idle_fin_addr", bus.pl_ddr_wr_addr, exp_addr());

    // Drain past empty; the level floors at zero
    n = $urandom_range(6, 9);
    for (int i = 0; i < n; i++) begin
      finish(1'b0, 1'b1);
      if (lvl_m > 0) lvl_m--;
      chk("drain_lvl", 32'(bus.ring_level), 32'(lvl_m));
    end

    // Continuous beats with no write finish: FIFO saturates, overrun sticks
    chk("ovr_pre", 32'(bus.overrun), 32'd0);
    s0 = starts_seen;
    bus.in_valid = 1'b1;
    repeat (40) tick();
    bus.in_valid = 1'b0;
    chk("ovr_one_start", 32'(starts_seen - s0), 32'd1);
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    chk("ovr_busy", 32'(bus.busy), 32'd1);
    chk("ovr_addr", bus.pl_ddr_wr_addr, exp_addr());
    chk("ovr_no_tmo", 32'(bus.wr_timeout), 32'd0);
    finish(1'b1, 1'b0);
    wr_done++;
    lvl_m++;
    chk("ovr_lvl", 32'(bus.ring_level), 32'(lvl_m));
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);
    chk("ovr_relaunch", 32'(bus.pl_ddr_wr_start), 32'd1);
    chk("ovr_relaunch_addr", bus.pl_ddr_wr_addr, exp_addr());

    // Asynchronous reset in WAIT_FIN abandons the burst
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    rst_n = 1'b1;
    wr_done = 0;
    lvl_m = 0;

`ifdef WR_CTRL_TIMEOUT_EN
    // A second block is already buffered, so the relaunch needs no new beats
    send_beats(2 * BLOCK_BEATS);
    launch_and_check("post_rst");
    repeat (TIMEOUT_CYC - 1) tick();
    chk("tmo_not_yet", 32'(bus.wr_timeout), 32'd0);
    tick();
    chk("tmo_set", 32'(bus.wr_timeout), 32'd1);
    chk("tmo_lvl", 32'(bus.ring_level), 32'd0);
    launch_and_check("tmo_relaunch");
`else
    send_beats(BLOCK_BEATS);
    launch_and_check("post_rst");
    repeat (50) tick();
    chk("wait_forever_busy", 32'(bus.busy), 32'd1);
    chk("no_tmo", 32'(bus.wr_timeout), 32'd0);
`endif
    finish(1'b1, 1'b0);
    wr_done++;
    lvl_m++;
    chk("post_rst_lvl", 32'(bus.ring_level), 32'(lvl_m));
    chk("post_rst_addr", bus.pl_ddr_wr_addr, exp_addr());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
